// File: rtl/bin9_to_bcd_seq.sv
// bin9_to_bcd_seq: sequential double-dabble 9-bit binary to 3-digit BCD; define BIN2BCD_SAT99_EN to saturate results >=100 to 99
module bin9_to_bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t      state;
  logic [8:0]  sr;
  logic [11:0] work;
  logic [3:0]  cnt;
  logic [11:0] fixed;
  logic [11:0] shifted;
  logic [11:0] result;
  // one iteration: add-3 correction of every nibble, then shift in the next binary bit
  always_comb begin
    fixed[11:8] = work[11:8] >= 4'd5 ? work[11:8] + 4'd3 : work[11:8];
    fixed[7:4]  = work[7:4]  >= 4'd5 ? work[7:4]  + 4'd3 : work[7:4];
    fixed[3:0]  = work[3:0]  >= 4'd5 ? work[3:0]  + 4'd3 : work[3:0];
    shifted     = {fixed[10:0], sr[8]};
`ifdef BIN2BCD_SAT99_EN
    result      = |shifted[11:8] ? 12'h099 : shifted;
`else
    result      = shifted;
`endif
  end
  // control FSM, working registers and registered output digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sr           <= '0;
      work         <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bcd_hundreds <= '0;
      bcd_tens     <= '0;
      bcd_ones     <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= SHIFT;
          sr    <= bin;
          work  <= '0;
          cnt   <= 4'd9;
          busy  <= 1'b1;
        end
      end else begin
        sr   <= {sr[7:0], 1'b0};
        work <= shifted;
        cnt  <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          state        <= IDLE;
          busy         <= 1'b0;
          done         <= 1'b1;
          bcd_hundreds <= result[11:8];
          bcd_tens     <= result[7:4];
          bcd_ones     <= result[3:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_bin9_to_bcd_seq.sv
// tb_bin9_to_bcd_seq: randomized self-checking bench against a decimal-arithmetic reference model
module tb_bin9_to_bcd_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] bin = '0;
  logic       busy, done;
  logic [3:0] bcd_hundreds, bcd_tens, bcd_ones;
  int checks = 0;
  int errors = 0;
  bin9_to_bcd_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .busy(busy), .done(done),
    .bcd_hundreds(bcd_hundreds), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
  );
  always #5 clk = ~clk;
  function automatic int ref_bcd(input int v);
    int e = v;
`ifdef BIN2BCD_SAT99_EN
    if (e >= 100) e = 99;
`endif
    return ((e / 100) << 8) | (((e / 10) % 10) << 4) | (e % 10);
  endfunction
  function automatic int digits();
    return int'({bcd_hundreds, bcd_tens, bcd_ones});
  endfunction
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int v);
    int lat = 0;
    int bcyc = 0;
    @(negedge clk);
    bin = 9'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin = 9'($urandom);
    while (!done && lat < 20) begin
      if (busy) bcyc++;
      lat++;
      @(negedge clk);
    end
    check("latency", lat, 9);
    check("busy_len", bcyc, 9);
    check("busy_at_done", int'(busy), 0);
    check("digits", digits(), ref_bcd(v));
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    check("digits_hold", digits(), ref_bcd(v));
  endtask
  initial begin
    int nd, gap;
    start = 1'b1;
    bin = 9'd123;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_digits", digits(), 0);
    rst_n = 1'b1;
    start = 1'b0;
    run(0);
    run(31);
    run(9);
    run(10);
    run(511);
    run(100);
    run(99);
    @(negedge clk);
    bin = 9'd255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bin = 9'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        check("ignore_digits", digits(), ref_bcd(255));
      end
    end
    check("ignore_done_count", nd, 1);
    check("ignore_hold", digits(), ref_bcd(255));
    bin = 9'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_digits", digits(), 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    rst_n = 1'b1;
    run(45);
    @(negedge clk);
    bin = 9'd12;
    start = 1'b1;
    nd = 0;
    while (!done && nd < 25) begin
      nd++;
      @(negedge clk);
    end
    check("held_first_done", int'(done), 1);
    check("held_first", digits(), ref_bcd(12));
    bin = 9'd300;
    gap = 0;
    do begin
      gap++;
      @(negedge clk);
    end while (!done && gap < 25);
    start = 1'b0;
    check("held_gap", gap, 10);
    check("held_second", digits(), ref_bcd(300));
    repeat (12) @(negedge clk);
    check("held_idle_busy", int'(busy), 0);
    for (int i = 0; i < 20; i++) run(int'($urandom_range(0, 511)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
